dice_roll_scheduler: RTL and testbench
======================================

# dice_roll_scheduler

Round-robin scheduler that shares one `dice_roller` instance between `NUM_REQ` requesters. It latches the granted requester's die selection and drives the roller's `roll` input high for a fixed number of cycles. It then captures `rolled_number` and returns the value to the granted requester with a one-cycle acknowledge. The block sits between game-logic clients and the single roller datapath.

## Interface

- `NUM_REQ`, 4, number of requesters (2..8)
- `ROLL_CYCLES`, 8, cycles `roll_out` is held high per roll (≥1)
- `IDW`, `$clog2(NUM_REQ)`, requester index width (derived, not overridden)

Ports:

- `clock`  in  1  single clock, rising-edge
- `reset`  in  1  synchronous, active-high
- `req`  in  NUM_REQ  per-requester roll request (level); held until matching `ack`
- `req_die`  in  2*NUM_REQ  die select per requester; requester i uses bits [2i+1:2i]
- `ack`  out  NUM_REQ  one-hot, one-cycle pulse: `result` valid for that requester
- `result`  out  8  captured rolled number; holds until next capture
- `result_id`  out  IDW  index of requester that owns `result`
- `busy`  out  1  high whenever state ≠ IDLE
- `roll_out`  out  1  to roller `roll`
- `die_select_out`  out  2  to roller `die_select`; stable for the whole roll
- `rolled_number_in`  in  8  from roller `rolled_number`
- `roll_count`  out  16  present only with `DICE_SCHED_STATS_EN`

## Operation

- **Reset values:**
  - `ack`=0, `result`=0, `result_id`=0, `busy`=0.
  - `roll_out`=0, `die_select_out`=2'b00, state IDLE.
  - RR pointer `last`=NUM_REQ-1, so requester 0 has priority first.
  - `roll_count`=0.
- **FSM states:** IDLE, ROLL, SETTLE, CAPTURE.
- **IDLE:**
  - Computes eligible = `req & ~ack`. The requester currently being acked is masked, so a req that has not yet dropped is not re-granted.
  - If eligible≠0, it grants the first set bit searching from `last+1` with wrap.
  - On grant, at that edge: `grant_id` latched, `die_select_out` ← that requester's `req_die`, `roll_out`←1, counter←ROLL_CYCLES-1, `last`←grant_id, state→ROLL.
- **ROLL:**
  - `roll_out` stays 1 and the counter decrements each cycle.
  - At counter=0: `roll_out`←0, state→SETTLE.
- **SETTLE:** one cycle with `roll_out`=0 so the roller output is stable. State→CAPTURE.
- **CAPTURE:**
  - `result`←`rolled_number_in`, `result_id`←grant_id, `ack`←onehot(grant_id), state→IDLE.
  - `ack` self-clears the following cycle.
- **Request handling:**
  - `req_die` is sampled only at grant; later changes are ignored until the next grant.
  - If `req` is dropped mid-roll, the roll still completes and `ack` still pulses. There is no cancel.
- **Invalid selection:** `die_select`=2'b11 is forwarded unchanged; invalid-die handling is the roller's job.
- **Reset mid-operation:** returns to reset values at that edge. No `ack` is issued for the aborted roll, and `roll_out` is low the cycle after reset is sampled.

## Timing

- Req sampled in IDLE at edge E0:
  - `roll_out` is high for cycles E0..E0+ROLL_CYCLES.
  - SETTLE follows.
  - `result` and `ack` are valid in the cycle after edge E0+ROLL_CYCLES+2.
- Grant-to-ack latency is ROLL_CYCLES+2 edges (10 for the default).
- Minimum spacing between consecutive grants is ROLL_CYCLES+3 cycles. The next grant can occur at the edge where the previous `ack` is high, subject to masking.
- Simultaneous requests are served strictly round-robin. Under full load each requester waits at most (NUM_REQ-1)·(ROLL_CYCLES+3) cycles after the current roll.
- `result` and `result_id` change only at CAPTURE.

## Configuration

- **`DICE_SCHED_STATS_EN` defined:**
  - Adds output `roll_count[15:0]`, which increments at every CAPTURE and saturates at 16'hFFFF.
  - Cleared by `reset`.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan

- **Single request:** reset 2 cycles, `req`=4'b0100, `req_die[5:4]`=2'b01, roller stub returns 8'd5.
  - `die_select_out`=2'b01.
  - `roll_out` high exactly 8 cycles.
  - `ack`=4'b0100 for 1 cycle, 10 edges after grant.
  - `result`=5, `result_id`=2.
- **All four requesting continuously:** grants go 0,1,2,3,0. Each `ack` is one-hot, acks are spaced 11 cycles apart, and there are no repeats before wrap.
- **Req held through ack:**
  - Requester 1 keeps `req` high one cycle past its `ack` with no others requesting: no second grant occurs in the ack cycle.
  - Regrant occurs on the next cycle.
- **Reset mid-roll:**
  - Assert `reset` at ROLL cycle 4: `roll_out`=0 and `busy`=0 next cycle, and no `ack` for that roll.
  - A fresh `req` is then served normally.
- **Mid-roll changes:** `req_die` changed from 2'b00 to 2'b11 during ROLL: `die_select_out` stays 2'b00 until the next grant.
- **With `DICE_SCHED_STATS_EN`:** 3 completed rolls give `roll_count`=3; after reset `roll_count`=0.

Source files
------------

// File: rtl/dice_roll_scheduler.sv
// rtl/dice_roll_scheduler.sv - round-robin sharing of one dice roller among NUM_REQ requesters
// Optional roll statistics counter enabled by DICE_SCHED_STATS_EN.
module dice_roll_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ROLL_CYCLES = 8,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_die,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           result,
  output logic [IDW-1:0]       result_id,
  output logic                 busy,
  output logic                 roll_out,
  output logic [1:0]           die_select_out,
  input  logic [7:0]           rolled_number_in
`ifdef DICE_SCHED_STATS_EN
  ,
  output logic [15:0]          roll_count
`endif
);

  localparam int CW = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
  localparam logic [IDW:0]  NREQ     = (IDW+1)'(NUM_REQ);
  localparam logic [CW-1:0] CNT_INIT = CW'(ROLL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ROLL, SETTLE, CAPTURE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [IDW-1:0]     last;
  logic [IDW-1:0]     grant_id;
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [IDW-1:0]     pick;
  logic [1:0]         pick_die;

  // The requester being acked this cycle is masked so a lingering req is not re-granted.
  always_comb eligible = req & ~ack;

  always_comb begin
    logic [IDW:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last} + (IDW+1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    pick_die = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDW'(i)) pick_die = req_die[2*i +: 2];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      last           <= IDW'(NUM_REQ - 1);
      grant_id       <= '0;
      ack            <= '0;
      result         <= '0;
      result_id      <= '0;
      busy           <= 1'b0;
      roll_out       <= 1'b0;
      die_select_out <= 2'b00;
`ifdef DICE_SCHED_STATS_EN
      roll_count     <= '0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id       <= pick;
            die_select_out <= pick_die;
            roll_out       <= 1'b1;
            count          <= CNT_INIT;
            last           <= pick;
            busy           <= 1'b1;
            state          <= ROLL;
          end
        end
        ROLL: begin
          if (count == '0) begin
            roll_out <= 1'b0;
            state    <= SETTLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        SETTLE: state <= CAPTURE;
        CAPTURE: begin
          result    <= rolled_number_in;
          result_id <= grant_id;
          ack       <= NUM_REQ'(1) << grant_id;
          busy      <= 1'b0;
          state     <= IDLE;
`ifdef DICE_SCHED_STATS_EN
          if (roll_count != 16'hFFFF) roll_count <= roll_count + 16'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// tb/tb_dice_roll_scheduler.sv - scoreboard bench for dice_roll_scheduler
// Optional roll_count checks follow DICE_SCHED_STATS_EN.
module tb_dice_roll_scheduler;

  localparam int N   = 4;
  localparam int RC  = 8;
  localparam int LAT = RC + 2;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [2*N-1:0] req_die;
  logic [N-1:0] ack;
  logic [7:0]   result;
  logic [1:0]   result_id;
  logic         busy;
  logic         roll_out;
  logic [1:0]   die_select_out;
  logic [7:0]   rolled_number_in;
`ifdef DICE_SCHED_STATS_EN
  logic [15:0]  roll_count;
`endif

  logic [7:0] lut [4];
  assign rolled_number_in = lut[die_select_out];

  dice_roll_scheduler #(.NUM_REQ(N), .ROLL_CYCLES(RC)) dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req),
    .req_die          (req_die),
    .ack              (ack),
    .result           (result),
    .result_id        (result_id),
    .busy             (busy),
    .roll_out         (roll_out),
    .die_select_out   (die_select_out),
    .rolled_number_in (rolled_number_in)
`ifdef DICE_SCHED_STATS_EN
    ,
    .roll_count       (roll_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int id;
    int val;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   log_id[$];
  int   log_cyc[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: who was granted when, and what each requester is doing.
  int cur_g   = -100;
  int m_die   = 0;
  int free_at = 0;
  int mask_at = -1;
  int mask_id = 0;
  int last    = N - 1;
  int n       = 0;
  int drop_at [N];
  bit hold    [N];
  bit cont    [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, expv, cyc);
    end
  endtask

  task automatic grant(input int id);
    int die;
    die = int'(req_die[2*id +: 2]);
    q.push_back('{id, int'(lut[die]), n + LAT});
    cur_g   = n;
    m_die   = die;
    free_at = n + LAT + 1;
    mask_at = free_at;
    mask_id = id;
    last    = id;
    if (!cont[id]) drop_at[id] = n + LAT + (hold[id] ? 2 : 0);
    hold[id] = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] rv;
    bit got;
    int id;
    if (reset) begin
      q.delete();
      cur_g = -100; free_at = n + 1; mask_at = -1; last = N - 1; m_die = 0;
      for (int i = 0; i < N; i++) begin drop_at[i] = -1; hold[i] = 1'b0; end
      req = '0;
    end else if (n >= free_at) begin
      rv = req;
      if (mask_at == n) rv[mask_id] = 1'b0;
      got = 1'b0;
      for (int k = 1; k <= N; k++) begin
        id = (last + k) % N;
        if (!got && rv[id]) begin
          got = 1'b1;
          grant(id);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (drop_at[i] == n) begin req[i] = 1'b0; drop_at[i] = -1; end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    n = cyc;
    model_edge();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      step();
      if (q.size() == 0 && req == '0) done = 1'b1;
    end
    if (!done) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever an ack is presented or one is due.
  int   m_res = 0;
  int   m_rid = 0;
  int   m_cnt = 0;
  logic rst_q = 1'b1;
  always @(posedge clock) rst_q <= reset;

  initial begin
    exp_t e;
    bit   due;
    int   aid;
    forever begin
      @(negedge clock);
      if (cyc >= 1) begin
        if (rst_q) begin m_res = 0; m_rid = 0; m_cnt = 0; end
        due = (q.size() > 0) && (q[0].cyc == cyc);
        if (ack != '0 || due) begin
          if (!due) begin
            chk("unexpected_ack", 32'(ack), 32'd0);
          end else begin
            e = q.pop_front();
            chk("ack_onehot", 32'(ack), 32'(1) << e.id);
            m_res = e.val;
            m_rid = e.id;
            m_cnt++;
            aid = -1;
            for (int i = 0; i < N; i++) if (ack[i]) aid = i;
            log_id.push_back(aid);
            log_cyc.push_back(cyc);
          end
        end
        chk("result", 32'(result), 32'(m_res));
        chk("result_id", 32'(result_id), 32'(m_rid));
        chk("roll_out", 32'(roll_out), 32'(cyc >= cur_g && cyc < cur_g + RC));
        chk("busy", 32'(busy), 32'(cyc >= cur_g && cyc < cur_g + LAT));
        chk("die_select_out", 32'(die_select_out), 32'(m_die));
`ifdef DICE_SCHED_STATS_EN
        chk("roll_count", 32'(roll_count), 32'(m_cnt));
`endif
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset = 1'b1; req = '0; req_die = '0;
    lut[0] = 8'd17; lut[1] = 8'd5; lut[2] = 8'd99; lut[3] = 8'd200;
    for (int i = 0; i < N; i++) begin drop_at[i] = -1; hold[i] = 1'b0; cont[i] = 1'b0; end
    step();
    step();
    reset = 1'b0;

    // Single request from requester 2 with die 01.
    log_id.delete(); log_cyc.delete();
    s = n;
    req_die[5:4] = 2'b01;
    req[2] = 1'b1;
    wait_idle();
    chk("single_ack_count", 32'(log_id.size()), 32'd1);
    if (log_id.size() >= 1) begin
      chk("single_ack_id", 32'(log_id[0]), 32'd2);
      chk("single_ack_cycle", 32'(log_cyc[0]), 32'(s + 1 + LAT));
    end
    chk("single_result", 32'(result), 32'd5);

    // All four requesting continuously after reset.
    reset_pulse();
    log_id.delete(); log_cyc.delete();
    for (int i = 0; i < N; i++) cont[i] = 1'b1;
    req = '1;
    repeat (56) step();
    for (int i = 0; i < N; i++) cont[i] = 1'b0;
    req = '0;
    wait_idle();
    chk("rr_ack_count_ge5", 32'(log_id.size() >= 5), 32'd1);
    if (log_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("rr_order", 32'(log_id[k]), 32'(k % N));
      for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(log_cyc[k] - log_cyc[k-1]), 32'(LAT + 1));
    end

    // Requester 1 keeps req high past its ack.
    reset_pulse();
    log_id.delete(); log_cyc.delete();
    s = n;
    req_die[3:2] = 2'b10;
    hold[1] = 1'b1;
    req[1] = 1'b1;
    wait_idle();
    chk("hold_ack_count", 32'(log_id.size()), 32'd2);
    if (log_id.size() == 2) begin
      chk("hold_first_ack", 32'(log_cyc[0]), 32'(s + 1 + LAT));
      chk("hold_regrant_ack", 32'(log_cyc[1]), 32'(s + 1 + LAT + 2 + LAT));
    end

    // Reset during ROLL, then a fresh request.
    reset_pulse();
    req_die[1:0] = 2'b10;
    req[0] = 1'b1;
    step();
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_roll_out", 32'(roll_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    log_id.delete(); log_cyc.delete();
    s = n;
    req_die[7:6] = 2'b11;
    req[3] = 1'b1;
    wait_idle();
    chk("after_abort_ack_count", 32'(log_id.size()), 32'd1);
    if (log_id.size() == 1) begin
      chk("after_abort_id", 32'(log_id[0]), 32'd3);
      chk("after_abort_cycle", 32'(log_cyc[0]), 32'(s + 1 + LAT));
    end
    chk("after_abort_result", 32'(result), 32'd200);

    // req_die change during ROLL is ignored until the next grant.
    req_die[1:0] = 2'b00;
    req[0] = 1'b1;
    repeat (3) step();
    req_die[1:0] = 2'b11;
    wait_idle();
    chk("die_hold_after_roll", 32'(die_select_out), 32'd0);
    chk("die_hold_result", 32'(result), 32'd17);
    req[0] = 1'b1;
    wait_idle();
    chk("die_after_regrant", 32'(die_select_out), 32'd3);
    chk("result_after_regrant", 32'(result), 32'd200);

`ifdef DICE_SCHED_STATS_EN
    reset_pulse();
    for (int r = 0; r < 3; r++) begin
      req[r] = 1'b1;
      wait_idle();
    end
    chk("stats_three_rolls", 32'(roll_count), 32'd3);
    reset_pulse();
    chk("stats_after_reset", 32'(roll_count), 32'd0);
`endif

    // Randomized traffic with occasional resets.
    lut[0] = 8'($urandom_range(0, 100));
    for (int k = 1; k < 4; k++) lut[k] = lut[k-1] + 8'($urandom_range(1, 50));
    for (int t = 0; t < 600; t++) begin
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && drop_at[i] < 0 && $urandom_range(0, 5) == 0) begin
          req_die[2*i +: 2] = 2'($urandom_range(0, 3));
          hold[i] = ($urandom_range(0, 3) == 0);
          req[i] = 1'b1;
        end else if ($urandom_range(0, 9) == 0) begin
          req_die[2*i +: 2] = 2'($urandom_range(0, 3));
        end
      end
    end
    reset = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) begin drop_at[i] = -1; hold[i] = 1'b0; end
    wait_idle();
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
